// File: rtl/audio_i2s_pkg.sv
// Shared types and defaults for the I2S transmitter slice.
package audio_i2s_pkg;

  localparam int SAMPLE_W           = 16;
  localparam int SAMPLE_IDX_W       = $clog2(SAMPLE_W);
  localparam int UNDERRUN_W         = 8;
  localparam int BCLK_HALF_DIV_DFLT = 8;
  localparam int SLOT_BITS_DFLT     = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Stereo sample stream from the synth core into the I2S transmitter.
interface audio_i2s_tx_if;
  import audio_i2s_pkg::*;

  sample_t sample_left;
  sample_t sample_right;
  logic    sample_valid;
  logic    sample_ready;

  modport master (
    output sample_left, sample_right, sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left, sample_right, sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles i2s_bclk every HALF_DIV system clocks and flags
// the cycle on which each edge is about to happen.
module i2s_bclk_gen #(
  parameter int HALF_DIV = 8
) (
  input  logic clk_50mhz,
  input  logic reset,
  output logic i2s_bclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             term;

  assign term     = (div_cnt == CNT_LAST);
  // Strobes coincide with the edge that flips i2s_bclk
  assign fall_stb = term && i2s_bclk;
  assign rise_stb = term && !i2s_bclk;

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (term) begin
      div_cnt  <= '0;
      i2s_bclk <= !i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter with a one-entry holding buffer; repeats the last
// frame and counts the event when the synth core falls behind.
module audio_i2s_tx
  import audio_i2s_pkg::*;
#(
  parameter int BCLK_HALF_DIV = BCLK_HALF_DIV_DFLT,
  parameter int SLOT_BITS     = SLOT_BITS_DFLT
) (
  input  logic                  clk_50mhz,
  input  logic                  reset,
  audio_i2s_tx_if.slave         snk,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  frame_start,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BC_W       = $clog2(FRAME_BITS);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(FRAME_BITS - 1);
  localparam logic [BC_W-1:0] SLOT_LIM = BC_W'(SLOT_BITS);

  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Slot position 1..16 carries the word MSB-first; position 0 and the tail pad with 0
  function automatic logic slot_bit(input sample_t word, input logic [BC_W-1:0] pos);
    logic [BC_W-1:0] msb_pos;
    msb_pos = BC_W'(SAMPLE_W);
    if (pos != '0 && pos <= msb_pos)
      return word[SAMPLE_IDX_W'(msb_pos - pos)];
    return 1'b0;
  endfunction

  logic            bclk_fall;
  logic [BC_W-1:0] bit_cnt;
  logic [BC_W-1:0] bit_nxt;
  logic [BC_W-1:0] slot_pos;
  logic            in_right;
  logic            tx_bit;
  sample_t         tx_word;
  logic            load;
  logic            capture;
  logic            hold_full;
  logic            ready_q;
  sample_t         hold_l;
  sample_t         hold_r;
  sample_t         frame_l;
  sample_t         frame_r;

  i2s_bclk_gen #(
    .HALF_DIV (BCLK_HALF_DIV)
  ) u_bclk_gen (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .i2s_bclk  (i2s_bclk),
    .fall_stb  (bclk_fall),
    .rise_stb  ()
  );

  assign load             = bclk_fall && (bit_cnt == BC_LAST);
  assign capture          = snk.sample_valid && ready_q;
  assign snk.sample_ready = ready_q;

  always_comb begin
    bit_nxt  = (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
    in_right = (bit_nxt >= SLOT_LIM);
    slot_pos = in_right ? (bit_nxt - SLOT_LIM) : bit_nxt;
    tx_word  = in_right ? frame_r : frame_l;
    tx_bit   = slot_bit(tx_word, slot_pos);
  end

  // Holding data needs no reset: it is only read while hold_full is set
  always_ff @(posedge clk_50mhz) begin
    if (capture) begin
      hold_l <= snk.sample_left;
      hold_r <= snk.sample_right;
    end
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      bit_cnt        <= BC_LAST;
      i2s_lrclk      <= 1'b0;
      i2s_sdata      <= 1'b0;
      frame_start    <= 1'b0;
      underrun_count <= '0;
      hold_full      <= 1'b0;
      ready_q        <= 1'b1;
      frame_l        <= '0;
      frame_r        <= '0;
    end else begin
      frame_start <= load;
      // Ready trails the holding flag by a cycle, but drops at once on capture
      ready_q     <= capture ? 1'b0 : !hold_full;

      if (bclk_fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= in_right;
        i2s_sdata <= tx_bit;
      end

      if (load) begin
        if (hold_full) begin
          frame_l   <= hold_l;
          frame_r   <= hold_r;
          hold_full <= 1'b0;
        end else begin
          underrun_count <= sat_inc(underrun_count);
        end
      end

      // A capture never coincides with a load that empties holding (ready is low)
      if (capture)
        hold_full <= 1'b1;
    end
  end

endmodule
